// File: rtl/fifo_ctrl.sv
// Sequencing controller for an 8-entry FIFO: decodes write/read requests into a
// one-cycle operation code, keeps head/tail pointers and occupancy, and drives storage strobes.
module fifo_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic       rd_en,
  output logic [2:0] state,
  output logic [3:0] data_count,
  output logic [2:0] head,
  output logic [2:0] tail,
  output logic       we,
  output logic [2:0] wr_addr,
  output logic       re,
  output logic [2:0] rd_addr
);

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    WRITE    = 3'b001,
    READ     = 3'b010,
    WR_ERROR = 3'b011,
    RD_ERROR = 3'b100
  } state_e;

  localparam logic [3:0] DEPTH = 4'd8;

  state_e     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic [2:0] head_q, head_d;
  logic [2:0] tail_q, tail_d;
  logic       we_q, we_d;
  logic       re_q, re_d;
  logic [2:0] wr_addr_q, wr_addr_d;
  logic [2:0] rd_addr_q, rd_addr_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      count_q   <= 4'd0;
      head_q    <= 3'd0;
      tail_q    <= 3'd0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      wr_addr_q <= 3'd0;
      rd_addr_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      we_q      <= we_d;
      re_q      <= re_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // Every state lasts one cycle; simultaneous or absent requests fall to IDLE.
  always_comb begin
    state_d   = IDLE;
    count_d   = count_q;
    head_d    = head_q;
    tail_d    = tail_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    case ({wr_en, rd_en})
      2'b10: begin
        if (count_q == DEPTH) begin
          state_d = WR_ERROR;
        end else begin
          state_d   = WRITE;
          we_d      = 1'b1;
          wr_addr_d = tail_q;
          tail_d    = tail_q + 3'd1;
          count_d   = count_q + 4'd1;
        end
      end
      2'b01: begin
        if (count_q == 4'd0) begin
          state_d = RD_ERROR;
        end else begin
          state_d   = READ;
          re_d      = 1'b1;
          rd_addr_d = head_q;
          head_d    = head_q + 3'd1;
          count_d   = count_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign state      = state_q;
  assign data_count = count_q;
  assign head       = head_q;
  assign tail       = tail_q;
  assign we         = we_q;
  assign re         = re_q;
  assign wr_addr    = wr_addr_q;
  assign rd_addr    = rd_addr_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: a queue-based occupancy model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en, rd_en;
  logic [2:0] state;
  logic [3:0] data_count;
  logic [2:0] head, tail;
  logic       we, re;
  logic [2:0] wr_addr, rd_addr;

  int tests = 0;
  int fails = 0;

  fifo_ctrl dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .rd_en(rd_en),
    .state(state), .data_count(data_count), .head(head), .tail(tail),
    .we(we), .wr_addr(wr_addr), .re(re), .rd_addr(rd_addr)
  );

  always #5 clk = ~clk;

  // Model: slots currently occupied, oldest first; pointers follow from totals mod 8.
  int slots[$];
  int n_writes, n_reads;
  int m_state, m_we, m_re, m_wa, m_ra;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slots.delete();
      n_writes = 0; n_reads = 0;
      m_state = 0; m_we = 0; m_re = 0; m_wa = 0; m_ra = 0;
    end else begin
      m_we = 0; m_re = 0; m_state = 0;
      if (wr_en && !rd_en) begin
        if (slots.size() == 8) m_state = 3;
        else begin
          m_state = 1; m_we = 1; m_wa = n_writes % 8;
          slots.push_back(n_writes % 8);
          n_writes++;
        end
      end else if (rd_en && !wr_en) begin
        if (slots.size() == 0) m_state = 4;
        else begin
          m_state = 2; m_re = 1;
          m_ra = slots.pop_front();
          n_reads++;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      check("model_state", state, m_state);
      check("model_count", data_count, slots.size());
      check("model_head", head, n_reads % 8);
      check("model_tail", tail, n_writes % 8);
      check("model_we", we, m_we);
      check("model_re", re, m_re);
      check("model_wr_addr", wr_addr, m_wa);
      check("model_rd_addr", rd_addr, m_ra);
    end
  end

  // Drive one request pair, then return just after the edge that samples it.
  task automatic applyStimulus(input logic w, input logic r);
    @(negedge clk); #1;
    wr_en = w; rd_en = r;
    @(posedge clk); #2;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp_wa[4];
    reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_state", state, 0);
    check("rst_count", data_count, 0);
    check("rst_head", head, 0);
    check("rst_tail", tail, 0);
    @(negedge clk); #1 reset_n = 1'b1;

    // Reset mid-operation
    repeat (3) applyStimulus(1'b1, 1'b0);
    check("pre_rst_count", data_count, 3);
    reset_n = 1'b0; #1;
    check("arst_state", state, 0);
    check("arst_count", data_count, 0);
    check("arst_tail", tail, 0);
    check("arst_we", we, 0);
    check("arst_wr_addr", wr_addr, 0);
    #1 reset_n = 1'b1;
    applyStimulus(1'b0, 1'b1);
    check("post_rst_rderr", state, 4);
    check("post_rst_count", data_count, 0);

    // Fill and overflow
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0);
      check("fill_state", state, 1);
      check("fill_wr_addr", wr_addr, i);
      check("fill_count", data_count, i + 1);
    end
    check("fill_tail_wrap", tail, 0);
    applyStimulus(1'b1, 1'b0);
    check("ovf_state", state, 3);
    check("ovf_we", we, 0);
    check("ovf_count", data_count, 8);
    applyStimulus(1'b1, 1'b0);
    check("ovf_repeat_state", state, 3);

    // Drain and underflow
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1);
      check("drain_state", state, 2);
      check("drain_rd_addr", rd_addr, i);
      check("drain_count", data_count, 7 - i);
    end
    check("drain_head_wrap", head, 0);
    applyStimulus(1'b0, 1'b1);
    check("udf_state", state, 4);
    check("udf_re", re, 0);

    // Wrap-around interleave
    repeat (6) applyStimulus(1'b1, 1'b0);
    repeat (6) applyStimulus(1'b0, 1'b1);
    exp_wa = '{6, 7, 0, 1};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0);
      check("wrap_wr_addr", wr_addr, exp_wa[i]);
    end
    check("wrap_tail", tail, 2);
    check("wrap_count", data_count, 4);

    // Simultaneous requests at count 3
    applyStimulus(1'b0, 1'b1);
    check("simul_pre_count", data_count, 3);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1);
      check("simul_state", state, 0);
      check("simul_count", data_count, 3);
      check("simul_head", head, 7);
      check("simul_tail", tail, 2);
      check("simul_we", we, 0);
      check("simul_re", re, 0);
    end

    // Alternating requests from empty
    repeat (3) applyStimulus(1'b0, 1'b1);
    check("alt_pre_count", data_count, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i % 2 == 0, i % 2 == 1);
      check("alt_state", state, (i % 2 == 0) ? 1 : 2);
      check("alt_count", data_count, (i % 2 == 0) ? 1 : 0);
    end

    applyStimulus(1'b0, 1'b0);
    check("final_idle", state, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Sequencing controller for the 8-entry FIFO. Samples the write/read requests every clock, decides the operation, and keeps the head/tail pointers and occupancy count. Issues single-cycle write/read strobes with addresses to the register-file storage. Its registered 3-bit state code and 4-bit data_count feed the FIFO output-flag decoder (empty/full/ack/err) directly.

## Interface
- Parameters: none. Depth is fixed at 8; pointers are 3 bits; the count is 4 bits (range 0..8).
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write request, sampled at each rising edge.
- rd_en  input  1  read request, sampled at each rising edge.
- state  output  3  registered operation code: IDLE=000, WRITE=001, READ=010, WR_ERROR=011, RD_ERROR=100.
- data_count  output  4  registered occupancy, 0..8.
- head  output  3  read pointer; the oldest entry.
- tail  output  3  write pointer; the next free slot.
- we  output  1  registered storage write strobe.
- wr_addr  output  3  registered storage write address.
- re  output  1  registered storage read strobe.
- rd_addr  output  3  registered storage read address.

## Operation
The next state is decoded from the sampled wr_en, rd_en and the current data_count:
- wr_en=1, rd_en=0, data_count<8: WRITE.
- wr_en=1, rd_en=0, data_count=8: WR_ERROR.
- rd_en=1, wr_en=0, data_count>0: READ.
- rd_en=1, wr_en=0, data_count=0: RD_ERROR.
- wr_en=rd_en (both 0 or both 1): IDLE. Simultaneous requests are a defined no-op.

Register updates on the edge that enters each state:
- WRITE: we=1, wr_addr=old tail, tail<=tail+1 (mod 8), data_count<=data_count+1.
- READ: re=1, rd_addr=old head, head<=head+1 (mod 8), data_count<=data_count-1.
- IDLE, WR_ERROR, RD_ERROR: pointers and count hold; we=0, re=0; wr_addr and rd_addr hold.

Rules:
- Pointers wrap from 7 to 0 with no special handling.
- data_count never leaves 0..8. Error states guarantee no increment at 8 and no decrement at 0.
- Each state lasts exactly one cycle. It is re-decoded every edge, with no sticky error. Holding wr_en=1 on a full FIFO gives WR_ERROR on every cycle.
- The state code is never 101..111. The next-state default is IDLE.
- Storage contents are not owned by this block.

## Timing
- Reset (reset_n=0, asynchronous, takes effect immediately) sets:
  - state=IDLE, data_count=0, head=0, tail=0
  - we=0, re=0, wr_addr=0, rd_addr=0
- Release is synchronous to the next rising edge. The first decode happens at the first edge with reset_n=1.
- Reset during any operation discards occupancy: count=0, pointers=0. Strobes drop in the same cycle.
- Request-to-state latency is 1 cycle. Request sampled at edge k gives state, strobe, address and the updated pointer/count, all valid after edge k.
- Storage write handshake: the storage samples we/wr_addr at edge k+1. The producer holds din stable through edge k+1.
- Storage read handshake: the storage samples re/rd_addr at edge k+1, and its dout is valid after edge k+1.
- Back-to-back operations are allowed every cycle (throughput is 1 operation/cycle).
- Count decisions always use the registered data_count present at the sampling edge.

## Test plan
- **Reset mid-operation:** write 3 entries, then pulse reset_n low between edges → all outputs 0 immediately. Next rd_en=1 → RD_ERROR, count stays 0.
- **Fill and overflow:** 9 consecutive wr_en=1 cycles from empty → 8 WRITE states with wr_addr 0..7 and count 1..8, tail wraps to 0. The 9th cycle is WR_ERROR with we=0 and count 8.
- **Drain and underflow:** from full, 9 consecutive rd_en=1 → 8 READ states with rd_addr 0..7 and count 7..0, head wraps to 0. The 9th cycle is RD_ERROR with re=0.
- **Wrap-around interleave:** write 6, read 6, then write 4 → the final writes use wr_addr 6,7,0,1, tail=2, count=4.
- **Simultaneous requests:** at count 3, wr_en=rd_en=1 for 2 cycles → state IDLE both cycles. Pointers, count, we and re are unchanged.
- **Alternating requests:** wr, rd, wr, rd from empty → state sequence 001, 010, 001, 010; count 1, 0, 1, 0; no error codes.
